unit_health_bank: RTL
=====================

Name: unit_health_bank

Overview:
- Per-side health store, one instance per side.
- Sits directly downstream of the damage decoder and consumes its 16 per-slot applied-damage values plus the tower applied-damage value.
- Each accepted combat tick does a saturating subtract of damage from every live slot's HP and from tower HP.
- Slots killed in that tick are reported one at a time as death events, over a valid/ready handshake, to the gold/score logic.

Parameters:
- TOWER_MAX_HP, 2000: tower HP loaded at reset; 12-bit value.
- REGEN_PERIOD, 64: accepted ticks between tower regen steps. Used only with TOWER_REGEN_EN.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high; all state returns to reset values on the next Clk edge.
- apply_valid  in  1  damage vector valid this cycle.
- apply_ready  out  1  bank can accept a damage vector.
- unit_damage  in  128  slot i damage at bits [8i+7:8i]; 8'hFF is the already-saturated maximum.
- tower_damage  in  8  damage to this side's tower.
- spawn_valid  in  1  spawn request.
- spawn_slot  in  4  slot to spawn into.
- spawn_hp  in  8  initial HP for the spawned unit.
- spawn_ready  out  1  spawn accepted this cycle when high together with spawn_valid.
- alive  out  16  per-slot live flags.
- rd_slot  in  4  HP readout select.
- rd_hp  out  8  combinational read of hp[rd_slot].
- tower_hp  out  12  current tower HP.
- tower_destroyed  out  1  sticky; set when tower HP reaches 0.
- death_valid  out  1  death event pending.
- death_slot  out  4  slot that died.
- death_ready  in  1  consumer accepts the death event.

Behaviour:
- Reset values:
  - hp[0..15]=0, alive=0, pending mask=0.
  - tower_hp=TOWER_MAX_HP, tower_destroyed=0.
  - state=IDLE, death_valid=0, death_slot=0, regen counter=0.
  - apply_ready=1 and spawn_ready=!alive[spawn_slot] (both in IDLE, with apply_valid low).
  - Reset during SCAN discards all undelivered death events.
- States:
  - IDLE: apply_ready=1.
  - SCAN: apply_ready=0, spawn_ready=0.
- IDLE, apply_valid=1 (tick accepted on this edge):
  - For each slot with alive[i]=1:
    - If d_i >= hp[i]: hp[i]<=0, alive[i]<=0, pending[i]<=1.
    - Else hp[i]<=hp[i]-d_i.
  - Slots with alive[i]=0 ignore damage entirely.
  - d_i=0 on a live slot leaves it unchanged.
  - Tower, when tower_destroyed=0: tower_hp<=tower_hp-tower_damage, saturating at 0 (compare in 12 bits after zero-extending tower_damage).
  - If the result is 0, tower_destroyed<=1 in the same edge.
  - Once destroyed, further tower damage is ignored; tower_hp stays 0.
  - If any slot died this tick: next state SCAN. Otherwise stay in IDLE.
  - Latency: new HP, alive and tower values are visible the cycle after acceptance.
- SCAN:
  - death_valid=1; death_slot = lowest-index set bit of the pending mask.
  - death_slot is registered and stable until the handshake.
  - On death_valid && death_ready: clear that pending bit; the next event appears the following cycle.
  - After the last bit clears: death_valid<=0, return to IDLE. Back-to-back accepts deliver one event per cycle.
  - death_ready held low: the bank stalls in SCAN indefinitely and apply_ready stays 0. The upstream holds its damage vector; no tick is lost.
- Spawn:
  - spawn_ready = (state==IDLE) && !apply_valid && !alive[spawn_slot]. Apply has priority in the same cycle.
  - On spawn handshake: hp[slot]<=spawn_hp, alive[slot]<=(spawn_hp!=0).
  - spawn_hp=0 completes the handshake but leaves the slot dead.
  - Spawn into a live slot is refused (spawn_ready=0).
- Width rules: all unit arithmetic is 8-bit unsigned; no wrap-around is possible because subtraction saturates at 0.

Optional Feature:
- Macro: TOWER_REGEN_EN.
- Defined:
  - A counter increments on each accepted tick.
  - When the count reaches REGEN_PERIOD, it wraps to 0 and tower_hp gains 1, capped at TOWER_MAX_HP.
  - Regen is applied after that tick's damage.
  - No regen once tower_destroyed=1.
  - The counter is 0 after reset.
- Not defined: no counter logic; tower HP only ever decreases until reset.

Test Plan:
- Reset, spawn slot 3 hp 100, apply unit_damage slot3=40 -> next cycle rd_hp(3)=60, alive[3]=1, death_valid=0, state stays IDLE.
- Slot 3 hp 60, apply 8'hFF -> hp 0, alive[3]=0; death_valid=1, death_slot=3 next cycle; death_ready=1 -> death_valid=0, apply_ready=1.
- Slots 1, 5 and 14 live with hp 10, apply damage 10 to each with death_ready held low 5 cycles -> death_slot stays 1 and apply_ready=0; then death_ready=1 -> events 1, 5, 14 on consecutive cycles, then IDLE.
- tower_damage=255 for 8 ticks from 2000 -> tower_hp=2000-2040 saturates to 0, tower_destroyed=1; further damage leaves tower_hp=0.
- spawn_valid and apply_valid high in the same IDLE cycle -> spawn_ready=0, apply takes effect; spawn completes the next cycle. Spawn into a live slot -> spawn_ready=0.
- With TOWER_REGEN_EN, REGEN_PERIOD=4, tower at 1990, 4 ticks of damage 0 -> tower_hp=1991. Reset asserted mid-SCAN -> death_valid=0, tower_hp=2000 next cycle.

Source files
------------

// File: rtl/unit_health_bank_if.sv
// Bus bundle for unit_health_bank: damage apply, spawn, HP readout, tower status
// and the death-event stream. "master" is the upstream/consumer side, "slave" is
// the bank itself.
interface unit_health_bank_if;
    logic         apply_valid;
    logic         apply_ready;
    logic [127:0] unit_damage;
    logic [7:0]   tower_damage;

    logic         spawn_valid;
    logic [3:0]   spawn_slot;
    logic [7:0]   spawn_hp;
    logic         spawn_ready;

    logic [15:0]  alive;
    logic [3:0]   rd_slot;
    logic [7:0]   rd_hp;
    logic [11:0]  tower_hp;
    logic         tower_destroyed;

    logic         death_valid;
    logic [3:0]   death_slot;
    logic         death_ready;

    modport master (
        output apply_valid, unit_damage, tower_damage,
        output spawn_valid, spawn_slot, spawn_hp,
        output rd_slot, death_ready,
        input  apply_ready, spawn_ready, alive, rd_hp,
        input  tower_hp, tower_destroyed, death_valid, death_slot
    );

    modport slave (
        input  apply_valid, unit_damage, tower_damage,
        input  spawn_valid, spawn_slot, spawn_hp,
        input  rd_slot, death_ready,
        output apply_ready, spawn_ready, alive, rd_hp,
        output tower_hp, tower_destroyed, death_valid, death_slot
    );
endinterface

// File: rtl/unit_health_bank.sv
// Per-side health store. Each accepted combat tick saturating-subtracts the
// decoded damage from every live slot and from the tower; slots killed on that
// tick are then reported one per handshake as death events, lowest index first.
// While events are pending the bank refuses new ticks and spawns.
// Optional feature macro: TOWER_REGEN_EN (periodic +1 tower regeneration).
module unit_health_bank #(
    parameter int unsigned TOWER_MAX_HP = 2000,
    parameter int unsigned REGEN_PERIOD = 64
) (
    input logic          clk,
    input logic          reset,
    unit_health_bank_if.slave bus
);

    localparam logic [0:0]  StIdle   = 1'b0;
    localparam logic [0:0]  StScan   = 1'b1;
    localparam logic [11:0] TowerMax = 12'(TOWER_MAX_HP);

    logic [0:0]  state_q, state_d;
    logic [7:0]  hp_q [16];
    logic [7:0]  hp_d [16];
    logic [15:0] alive_q, alive_d;
    logic [15:0] pend_q, pend_d;
    logic [11:0] tower_q, tower_d;
    logic        tower_dead_q, tower_dead_d;
    logic        death_valid_q, death_valid_d;
    logic [3:0]  death_slot_q, death_slot_d;

    logic        apply_fire;
    logic        spawn_ok;
    logic        spawn_fire;
    logic        death_fire;

    logic [7:0]  hp_hit [16];
    logic [15:0] kill;
    logic [11:0] tower_hit;
    logic        dead_hit;
    logic [11:0] tower_tick;
    logic [15:0] pend_left;

    // Lowest-index set bit; callers only use it on a non-zero mask.
    function automatic logic [3:0] lowest_set(input logic [15:0] mask);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Handshake qualifiers; an apply in the same cycle blocks the spawn.
    always_comb begin
        apply_fire = (state_q == StIdle) && bus.apply_valid;
        spawn_ok   = (state_q == StIdle) && !bus.apply_valid && !alive_q[bus.spawn_slot];
        spawn_fire = spawn_ok && bus.spawn_valid;
        death_fire = death_valid_q && bus.death_ready;
    end

    // Per-slot saturating damage; dead slots ignore damage entirely.
    always_comb begin
        kill = '0;
        for (int i = 0; i < 16; i++) begin
            hp_hit[i] = hp_q[i];
            if (alive_q[i]) begin
                if (bus.unit_damage[8*i +: 8] >= hp_q[i]) begin
                    hp_hit[i] = 8'd0;
                    kill[i]   = 1'b1;
                end else begin
                    hp_hit[i] = hp_q[i] - bus.unit_damage[8*i +: 8];
                end
            end
        end
    end

    // Tower damage, compared at 12 bits; once destroyed the tower stays at 0.
    always_comb begin
        tower_hit = tower_q;
        dead_hit  = tower_dead_q;
        if (!tower_dead_q) begin
            if ({4'd0, bus.tower_damage} >= tower_q) begin
                tower_hit = 12'd0;
                dead_hit  = 1'b1;
            end else begin
                tower_hit = tower_q - {4'd0, bus.tower_damage};
            end
        end
    end

`ifdef TOWER_REGEN_EN
    localparam int unsigned CntW = (REGEN_PERIOD > 1) ? $clog2(REGEN_PERIOD + 1) : 1;

    logic [CntW-1:0] regen_cnt_q, regen_cnt_d;
    logic [CntW-1:0] regen_inc;
    logic            regen_wrap;

    // Count accepted ticks; on wrap add one HP after this tick's damage.
    always_comb begin
        regen_inc   = regen_cnt_q + 1'b1;
        regen_wrap  = (regen_inc == CntW'(REGEN_PERIOD));
        regen_cnt_d = regen_cnt_q;
        tower_tick  = tower_hit;
        if (apply_fire) begin
            regen_cnt_d = regen_wrap ? '0 : regen_inc;
            if (regen_wrap && !dead_hit && (tower_hit < TowerMax)) begin
                tower_tick = tower_hit + 12'd1;
            end
        end
    end

    // Regen counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            regen_cnt_q <= '0;
        end else begin
            regen_cnt_q <= regen_cnt_d;
        end
    end
`else
    logic unused_regen_cfg;

    // No regeneration: the tower only loses HP until reset.
    always_comb begin
        tower_tick       = tower_hit;
        unused_regen_cfg = ^REGEN_PERIOD;
    end
`endif

    // Next-state: tick application, spawn and death-event draining.
    always_comb begin
        state_d       = state_q;
        alive_d       = alive_q;
        pend_d        = pend_q;
        tower_d       = tower_q;
        tower_dead_d  = tower_dead_q;
        death_valid_d = death_valid_q;
        death_slot_d  = death_slot_q;
        pend_left     = pend_q;
        for (int i = 0; i < 16; i++) begin
            hp_d[i] = hp_q[i];
        end

        unique case (state_q)
            StIdle: begin
                if (apply_fire) begin
                    for (int i = 0; i < 16; i++) begin
                        hp_d[i] = hp_hit[i];
                    end
                    alive_d      = alive_q & ~kill;
                    tower_d      = tower_tick;
                    tower_dead_d = dead_hit;
                    // The mask is empty in IDLE, so the kills form the whole batch.
                    pend_d       = kill;
                    if (kill != 16'd0) begin
                        state_d       = StScan;
                        death_valid_d = 1'b1;
                        death_slot_d  = lowest_set(kill);
                    end
                end else if (spawn_fire) begin
                    hp_d[bus.spawn_slot]    = bus.spawn_hp;
                    alive_d[bus.spawn_slot] = (bus.spawn_hp != 8'd0);
                end
            end
            StScan: begin
                if (death_fire) begin
                    pend_left               = pend_q;
                    pend_left[death_slot_q] = 1'b0;
                    pend_d                  = pend_left;
                    if (pend_left == 16'd0) begin
                        death_valid_d = 1'b0;
                        state_d       = StIdle;
                    end else begin
                        death_slot_d = lowest_set(pend_left);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset also discards any undelivered death events.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            alive_q       <= '0;
            pend_q        <= '0;
            tower_q       <= TowerMax;
            tower_dead_q  <= 1'b0;
            death_valid_q <= 1'b0;
            death_slot_q  <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                hp_q[i] <= 8'd0;
            end
        end else begin
            state_q       <= state_d;
            alive_q       <= alive_d;
            pend_q        <= pend_d;
            tower_q       <= tower_d;
            tower_dead_q  <= tower_dead_d;
            death_valid_q <= death_valid_d;
            death_slot_q  <= death_slot_d;
            for (int i = 0; i < 16; i++) begin
                hp_q[i] <= hp_d[i];
            end
        end
    end

    // Output drive.
    always_comb begin
        bus.apply_ready     = (state_q == StIdle);
        bus.spawn_ready     = spawn_ok;
        bus.alive           = alive_q;
        bus.rd_hp           = hp_q[bus.rd_slot];
        bus.tower_hp        = tower_q;
        bus.tower_destroyed = tower_dead_q;
        bus.death_valid     = death_valid_q;
        bus.death_slot      = death_slot_q;
    end

endmodule
